// File: rtl/gen_reduce.sv
// rtl/gen_reduce.sv - drains a generator stream and reduces it to sum/count/min/max
// Starts the upstream generator, accumulates every accepted element, then offers one result.
module gen_reduce #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  output logic             _up_start,
  output logic             _up_ready,
  input  logic             _up_valid,
  input  logic             _up_done,
  input  logic [WIDTH-1:0] _up_0,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [ACC_W-1:0] _sum,
  output logic [CNT_W-1:0] _count,
  output logic [WIDTH-1:0] _min,
  output logic [WIDTH-1:0] _max,
  output logic             _empty,
  output logic             _cnt_sat
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALL    = 3'd1,
    CONSUME = 3'd2,
    RESULT  = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t state;

  logic signed [ACC_W-1:0] elem_ext;
  logic                    take;
  logic                    cnt_full;
  logic                    elem_lt_min;
  logic                    elem_gt_max;

  assign elem_ext    = ACC_W'($signed(_up_0));
  assign take        = (state == CONSUME) && _up_valid;
  assign cnt_full    = &_count;
  assign elem_lt_min = $signed(_up_0) < $signed(_min);
  assign elem_gt_max = $signed(_up_0) > $signed(_max);

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      _up_start <= 1'b0;
      _up_ready <= 1'b0;
      _valid    <= 1'b0;
      _done     <= 1'b0;
      _sum      <= '0;
      _count    <= '0;
      _min      <= '0;
      _max      <= '0;
      _empty    <= 1'b0;
      _cnt_sat  <= 1'b0;
    end else if (_start) begin
      // A new call always wins; any run in progress is dropped silently.
      state     <= CALL;
      _up_start <= 1'b1;
      _up_ready <= 1'b0;
      _valid    <= 1'b0;
      _done     <= 1'b0;
      _sum      <= '0;
      _count    <= '0;
      _min      <= '0;
      _max      <= '0;
      _empty    <= 1'b1;
      _cnt_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        CALL: begin
          // _up_done may still be high from the previous upstream run; ignore it here.
          _up_start <= 1'b0;
          _up_ready <= 1'b1;
          state     <= CONSUME;
        end
        CONSUME: begin
          if (take) begin
            _sum   <= _sum + elem_ext;
            _empty <= 1'b0;
            if (cnt_full) begin
              _cnt_sat <= 1'b1;
            end else begin
              _count <= _count + 1'b1;
            end
            if (_empty || elem_lt_min) begin
              _min <= _up_0;
            end
            if (_empty || elem_gt_max) begin
              _max <= _up_0;
            end
          end
          if (_up_done) begin
            _up_ready <= 1'b0;
            _valid    <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (_ready) begin
            _valid <= 1'b0;
            _done  <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          _done <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
